// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   arbState_t : arbiter FSM states
//   grant_t    : which requester (instruction fetch or data stage) owns the port
//   DEFAULT_*  : default parameter values for mem_port_arbiter
package mem_arb_pkg;

  localparam int unsigned DEFAULT_DATA_W  = 32;
  localparam int unsigned DEFAULT_ADDR_W  = 32;
  localparam int unsigned DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2,
    DONE   = 2'd3
  } arbState_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one unified memory port between the
// instruction-fetch side (I_*) and the data stage (D_*).
//   CLK, RST             : clock, synchronous active-high reset
//   I_REQ/I_ADDR         : fetch request (held until I_DONE)
//   I_RDATA/I_DONE       : fetched word and one-cycle completion pulse
//   D_REQ/D_WE/D_ADDR/D_WDATA : data-stage load/store request
//   D_RDATA/D_DONE       : load result and one-cycle completion pulse
//   MEM_*                : unified memory request/response interface
//   ERR                  : one-cycle pulse when a transfer is abandoned on timeout
//   STALL_IF/STALL_MEM   : requester still waiting for its DONE
// A transfer takes grant -> XFER (one or more cycles) -> DONE. Contention
// alternates between the sides; the last grant is updated on DONE or timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic [DATA_W-1:0] I_RDATA,
  output logic              I_DONE,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              D_DONE,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  output logic              ERR,
  output logic              STALL_IF,
  output logic              STALL_MEM
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Count value during the last ackless XFER cycle before the timeout fires:
  // after that cycle the count would reach TIMEOUT.
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  arbState_t         state, stateNext;
  grant_t            lastGrant, lastGrantNext;
  grant_t            curGrant, curGrantNext;
  logic [ADDR_W-1:0] latchAddr;
  logic              latchWe;
  logic [DATA_W-1:0] latchWdata;
  logic [DATA_W-1:0] iRdata, dRdata;
  logic [CNT_W-1:0]  waitCnt;
  logic              errReg, errNext;
  logic              grantLoad, captureRd, cntInc;
  logic              inXfer, iBusy, dBusy;

  always_comb begin
    stateNext     = state;
    lastGrantNext = lastGrant;
    curGrantNext  = curGrant;
    grantLoad     = 1'b0;
    captureRd     = 1'b0;
    cntInc        = 1'b0;
    errNext       = 1'b0;
    case (state)
      IDLE: begin
        if (I_REQ || D_REQ) begin
          grantLoad = 1'b1;
          if (I_REQ && D_REQ)
            curGrantNext = (lastGrant == GRANT_I) ? GRANT_D : GRANT_I;
          else if (D_REQ)
            curGrantNext = GRANT_D;
          else
            curGrantNext = GRANT_I;
          stateNext = (curGrantNext == GRANT_D) ? D_XFER : I_XFER;
        end
      end
      I_XFER, D_XFER: begin
        // Ack is checked first so an ack on the final cycle beats the timeout.
        if (MEM_ACK) begin
          captureRd = 1'b1;
          stateNext = DONE;
        end else if ((TIMEOUT != 0) && (waitCnt == TO_LAST)) begin
          stateNext     = IDLE;
          lastGrantNext = curGrant;
          errNext       = 1'b1;
        end else begin
          cntInc = 1'b1;
        end
      end
      DONE: begin
        stateNext     = IDLE;
        lastGrantNext = curGrant;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      lastGrant  <= GRANT_I;
      curGrant   <= GRANT_I;
      latchAddr  <= '0;
      latchWe    <= 1'b0;
      latchWdata <= '0;
      iRdata     <= '0;
      dRdata     <= '0;
      waitCnt    <= '0;
      errReg     <= 1'b0;
    end else begin
      state     <= stateNext;
      lastGrant <= lastGrantNext;
      curGrant  <= curGrantNext;
      errReg    <= errNext;
      if (grantLoad) begin
        waitCnt <= '0;
        if (curGrantNext == GRANT_D) begin
          latchAddr  <= D_ADDR;
          latchWe    <= D_WE;
          latchWdata <= D_WDATA;
        end else begin
          latchAddr  <= I_ADDR;
          latchWe    <= 1'b0;
          latchWdata <= '0;
        end
      end else if (cntInc && (waitCnt != '1)) begin
        waitCnt <= waitCnt + 1'b1;
      end
      if (captureRd) begin
        if (curGrant == GRANT_I)
          iRdata <= MEM_RDATA;
        else if (!latchWe)
          dRdata <= MEM_RDATA;
      end
    end
  end

  assign inXfer    = (state == I_XFER) || (state == D_XFER);
  assign iBusy     = (state == I_XFER) || ((state == DONE) && (curGrant == GRANT_I));
  assign dBusy     = (state == D_XFER) || ((state == DONE) && (curGrant == GRANT_D));

  assign MEM_REQ   = inXfer;
  assign MEM_WE    = (state == D_XFER) && latchWe;
  assign MEM_ADDR  = latchAddr;
  assign MEM_WDATA = latchWdata;
  assign I_RDATA   = iRdata;
  assign D_RDATA   = dRdata;
  assign I_DONE    = (state == DONE) && (curGrant == GRANT_I);
  assign D_DONE    = (state == DONE) && (curGrant == GRANT_D);
  assign ERR       = errReg;
  assign STALL_IF  = (I_REQ || iBusy) && !I_DONE;
  assign STALL_MEM = (D_REQ || dBusy) && !D_DONE;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT = 16).
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        I_REQ;
  logic [31:0] I_ADDR;
  logic [31:0] I_RDATA;
  logic        I_DONE;
  logic        D_REQ;
  logic        D_WE;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic [31:0] D_RDATA;
  logic        D_DONE;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;
  logic        ERR;
  logic        STALL_IF;
  logic        STALL_MEM;

  int nCompared   = 0;
  int nMismatched = 0;

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_DONE(I_DONE),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_RDATA(D_RDATA), .D_DONE(D_DONE),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .ERR(ERR), .STALL_IF(STALL_IF), .STALL_MEM(STALL_MEM)
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set before the call are sampled on that edge,
  // outputs are read 1 ns after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearInputs();
    I_REQ = 1'b0; I_ADDR = '0;
    D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0; D_WDATA = '0;
    MEM_RDATA = '0; MEM_ACK = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  initial begin
    int   nDone;
    logic grantSeq [4];
    int   runI, runD, maxI, maxD;
    int   reqCycles, errAt, errCnt, doneCnt;
    logic reqAtErr;

    // ---- reset state ----
    doReset();
    checkVal("rst_mem_req", MEM_REQ, 0);
    checkVal("rst_mem_we", MEM_WE, 0);
    checkVal("rst_mem_addr", MEM_ADDR, 0);
    checkVal("rst_dones", {I_DONE, D_DONE, ERR}, 0);
    checkVal("rst_rdata", {I_RDATA, D_RDATA}, 0);

    // ---- single fetch; address change mid-transfer has no effect ----
    I_REQ = 1'b1; I_ADDR = 32'h40;
    step();                                   // grant
    checkVal("if_mem_req", MEM_REQ, 1);
    checkVal("if_mem_addr", MEM_ADDR, 32'h40);
    checkVal("if_mem_we", MEM_WE, 0);
    checkVal("if_stall", STALL_IF, 1);
    I_ADDR = 32'h999;
    step();                                   // XFER, no ack
    checkVal("if_addr_held", MEM_ADDR, 32'h40);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h2002000A;
    step();
    MEM_ACK = 1'b0;
    checkVal("if_done", I_DONE, 1);
    checkVal("if_rdata", I_RDATA, 32'h2002000A);
    checkVal("if_stall_done", STALL_IF, 0);
    I_REQ = 1'b0;
    step();
    checkVal("if_done_pulse", I_DONE, 0);

    // ---- minimum latency: request cycle 1, I_DONE in cycle 3 ----
    I_REQ = 1'b1; I_ADDR = 32'h40;
    step();
    MEM_ACK = 1'b1; MEM_RDATA = 32'h2002000A;
    step();
    MEM_ACK = 1'b0; I_REQ = 1'b0;
    checkVal("lat3_done", I_DONE, 1);
    step();

    // ---- ack while idle is ignored ----
    MEM_ACK = 1'b1; MEM_RDATA = 32'hBADBAD00;
    step();
    MEM_ACK = 1'b0;
    checkVal("idle_ack_dones", {I_DONE, D_DONE, MEM_REQ}, 0);
    checkVal("idle_ack_rdata", I_RDATA, 32'h2002000A);

    // ---- first contention after reset: D store first, then I ----
    doReset();
    I_REQ = 1'b1; I_ADDR = 32'h80;
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h100; D_WDATA = 32'hDEADBEEF;
    step();
    checkVal("cont_d_addr", MEM_ADDR, 32'h100);
    checkVal("cont_d_we", MEM_WE, 1);
    checkVal("cont_d_wdata", MEM_WDATA, 32'hDEADBEEF);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h55;
    step();
    MEM_ACK = 1'b0; D_REQ = 1'b0;
    checkVal("cont_d_done", {D_DONE, I_DONE}, 2'b10);
    checkVal("store_keeps_rdata", D_RDATA, 0);
    step();                                   // IDLE
    step();                                   // I granted
    checkVal("cont_i_addr", MEM_ADDR, 32'h80);
    checkVal("cont_i_we", MEM_WE, 0);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h1234;
    step();
    MEM_ACK = 1'b0; I_REQ = 1'b0;
    checkVal("cont_i_done", {D_DONE, I_DONE}, 2'b01);
    checkVal("cont_i_rdata", I_RDATA, 32'h1234);
    step();

    // ---- both held for 4 transfers: D,I,D,I; stall runs bounded ----
    doReset();
    I_REQ = 1'b1; I_ADDR = 32'h10;
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h20;
    nDone = 0; runI = 0; runD = 0; maxI = 0; maxD = 0;
    for (int c = 0; c < 40 && nDone < 4; c++) begin
      #1;
      runI = STALL_IF  ? runI + 1 : 0;
      runD = STALL_MEM ? runD + 1 : 0;
      if (runI > maxI) maxI = runI;
      if (runD > maxD) maxD = runD;
      if (D_DONE) begin grantSeq[nDone] = 1'b1; nDone++; end
      else if (I_DONE) begin grantSeq[nDone] = 1'b0; nDone++; end
      MEM_ACK = MEM_REQ; MEM_RDATA = 32'hA0 + 32'(c);
      step();
    end
    clearInputs();
    checkVal("alt_count", nDone, 4);
    checkVal("alt_order", {grantSeq[0], grantSeq[1], grantSeq[2], grantSeq[3]}, 4'b1010);
    checkVal("alt_stall_if_max", maxI, 5);
    checkVal("alt_stall_mem_max", maxD, 5);
    step();

    // ---- timeout: 16 ackless XFER cycles then ERR, no DONE ----
    doReset();
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h300;
    step();                                   // grant; first XFER cycle follows
    reqCycles = 0; errAt = 0; errCnt = 0; doneCnt = 0; reqAtErr = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      if (MEM_REQ) reqCycles++;
      if (I_DONE || D_DONE) doneCnt++;
      if (ERR) begin
        errCnt++; errAt = k; reqAtErr = MEM_REQ; D_REQ = 1'b0;
      end
      step();
    end
    checkVal("to_req_cycles", reqCycles, 16);
    checkVal("to_err_cycle", errAt, 17);
    checkVal("to_err_pulses", errCnt, 1);
    checkVal("to_req_dropped", reqAtErr, 0);
    checkVal("to_no_done", doneCnt, 0);

    // ---- ack on the last possible cycle beats the timeout; REQ dropped mid-way ----
    doReset();
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h304;
    step();
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) D_REQ = 1'b0;
      MEM_ACK = (k == 16); MEM_RDATA = 32'hCAFE0016;
      step();
    end
    MEM_ACK = 1'b0;
    checkVal("ackwin_done", D_DONE, 1);
    checkVal("ackwin_no_err", ERR, 0);
    checkVal("ackwin_rdata", D_RDATA, 32'hCAFE0016);
    step();
    checkVal("ackwin_no_err_after", ERR, 0);

    // ---- reset during D_XFER, then a fresh fetch ----
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h500; D_WDATA = 32'h77;
    step();
    step();
    checkVal("midrst_in_xfer", MEM_REQ, 1);
    D_REQ = 1'b0; RST = 1'b1;
    step();
    RST = 1'b0;
    checkVal("midrst_mem", {MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA}, 0);
    checkVal("midrst_flags", {I_DONE, D_DONE, ERR, STALL_IF, STALL_MEM}, 0);
    checkVal("midrst_rdata", {I_RDATA, D_RDATA}, 0);
    I_REQ = 1'b1; I_ADDR = 32'h44;
    step();
    checkVal("postrst_addr", {MEM_REQ, MEM_ADDR}, {1'b1, 32'h44});
    MEM_ACK = 1'b1; MEM_RDATA = 32'h600D;
    step();
    MEM_ACK = 1'b0; I_REQ = 1'b0;
    checkVal("postrst_done", {I_DONE, I_RDATA}, {1'b1, 32'h600D});
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule : tb_mem_port_arbiter
